ibex_rf_write_buffer: RTL

IBEX_RF_WRITE_BUFFER -- requirements
Module: ibex_rf_write_buffer

---
 rtl/ibex_pkg.sv | 13 +
 rtl/ibex_rf_write_buffer_if.sv | 28 ++
 rtl/ibex_rf_wb_fifo.sv | 63 ++++++
 rtl/ibex_rf_write_buffer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the register-file write buffer.
//   RfWbDataWidth : widest register word a buffered write can carry.
//   rf_wb_entry_t : one buffered writeback (destination address + data).
package ibex_pkg;

    localparam int unsigned RfWbDataWidth = 32;

    typedef struct packed {
        logic [4:0]               addr;
        logic [RfWbDataWidth-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/ibex_rf_write_buffer_if.sv
// ibex_rf_write_buffer_if: bus between the write buffer and the 2-port RF SRAM.
//   rf_raddr_a_o : port 1 read address
//   rf_addr_b_o  : port 2 address, shared by reads and writes
//   rf_we_o      : port 2 write enable
//   rf_wdata_o   : port 2 write data
//   rf_rdata_a_i : port 1 read data, one cycle after the address
//   rf_rdata_b_i : port 2 read data, one cycle after the address
// master = write buffer, slave = SRAM.
interface ibex_rf_write_buffer_if #(
    parameter int unsigned DataWidth = 32
);
    logic [4:0]           rf_raddr_a_o;
    logic [4:0]           rf_addr_b_o;
    logic                 rf_we_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [DataWidth-1:0] rf_rdata_a_i;
    logic [DataWidth-1:0] rf_rdata_b_i;

    modport master (
        output rf_raddr_a_o, rf_addr_b_o, rf_we_o, rf_wdata_o,
        input  rf_rdata_a_i, rf_rdata_b_i
    );

    modport slave (
        input  rf_raddr_a_o, rf_addr_b_o, rf_we_o, rf_wdata_o,
        output rf_rdata_a_i, rf_rdata_b_i
    );
endinterface

// File: rtl/ibex_rf_wb_fifo.sv
// ibex_rf_wb_fifo: in-order store of pending register writes.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i/push_entry_i : append an entry (caller never pushes into a full
//                      FIFO unless it pops in the same cycle)
//   pop_i            : retire the head entry
//   head_o           : oldest entry
//   age_entries_o    : all slots ordered oldest (index 0) to newest
//   age_valid_o      : which age slots hold a live entry
//   full_o, empty_o  : occupancy flags
module ibex_rf_wb_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  rf_wb_entry_t push_entry_i,
    input  logic         pop_i,
    output rf_wb_entry_t head_o,
    output rf_wb_entry_t age_entries_o [Depth],
    output logic [Depth-1:0] age_valid_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    rf_wb_entry_t    mem [Depth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // At full, push and pop hit the same slot; the pop still sees the old
    // entry combinationally this cycle, so nothing is lost.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= push_entry_i;
    end

    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            age_entries_o[i] = mem[rd_ptr + PtrW'(i)];
            age_valid_o[i]   = (CntW'(i) < count);
        end
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
endmodule

// File: rtl/ibex_rf_write_buffer.sv
// ibex_rf_write_buffer: writeback buffer in front of a 2-port register SRAM
// whose second port is shared between operand-B reads and writes.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   rd_req_i, need_b_i      : operand read request, operand B used
//   raddr_a_i, raddr_b_i    : operand addresses
//   rdata_a_o, rdata_b_o    : operand data, valid with rd_valid_o
//   rd_valid_o              : read issued last cycle completes now
//   stall_o                 : read not issued this cycle (B needed, buffer full)
//   we_i, waddr_i, wdata_i  : writeback, always accepted (x0 dropped)
//   rf                      : SRAM bus (master side)
//   wb_empty_o              : no buffered writes
// Writes are buffered and drained through port 2 whenever it is not serving
// an operand-B read. Reads bypass from the incoming write and the buffer.
// DataWidth must not exceed ibex_pkg::RfWbDataWidth.
module ibex_rf_write_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned WbDepth   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rd_req_i,
    input  logic                   need_b_i,
    input  logic [4:0]             raddr_a_i,
    input  logic [4:0]             raddr_b_i,
    output logic [DataWidth-1:0]   rdata_a_o,
    output logic [DataWidth-1:0]   rdata_b_o,
    output logic                   rd_valid_o,
    output logic                   stall_o,
    input  logic                   we_i,
    input  logic [4:0]             waddr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    ibex_rf_write_buffer_if.master rf,
    output logic                   wb_empty_o
);
    rf_wb_entry_t         head;
    rf_wb_entry_t         age_entries [WbDepth];
    logic [WbDepth-1:0]   age_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 drain;
    logic                 stall_int;
    logic                 b_read;
    logic                 issue;
    logic                 hit_a, hit_b;
    logic [DataWidth-1:0] byp_a, byp_b;

    logic                 vld_p1;
    logic                 zero_a_p1, zero_b_p1;
    logic                 hit_a_p1, hit_b_p1;
    logic [DataWidth-1:0] byp_a_p1, byp_b_p1;

    assign push      = we_i & (waddr_i != 5'd0);
    assign stall_int = rd_req_i & need_b_i & fifo_full;
    assign b_read    = rd_req_i & need_b_i & ~stall_int;
    assign issue     = rd_req_i & ~stall_int;
    // A full buffer always drains, which is why a push at full never overflows.
    assign drain     = ~fifo_empty & ~b_read & ~rst_i;

    ibex_rf_wb_fifo #(
        .Depth (WbDepth)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push),
        .push_entry_i  ('{addr: waddr_i, data: RfWbDataWidth'(wdata_i)}),
        .pop_i         (drain),
        .head_o        (head),
        .age_entries_o (age_entries),
        .age_valid_o   (age_valid),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign rf.rf_raddr_a_o = raddr_a_i;
    assign rf.rf_addr_b_o  = b_read ? raddr_b_i : head.addr;
    assign rf.rf_we_o      = drain;
    assign rf.rf_wdata_o   = DataWidth'(head.data);

    assign stall_o    = stall_int & ~rst_i;
    assign wb_empty_o = fifo_empty;

    // Bypass search: scan oldest to newest so newer matches override, then
    // let the incoming write override everything. The draining entry is
    // still in the age view this cycle, so it participates.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        byp_a = '0;
        byp_b = '0;
        for (int unsigned i = 0; i < WbDepth; i++) begin
            if (age_valid[i] && age_entries[i].addr == raddr_a_i) begin
                hit_a = 1'b1;
                byp_a = DataWidth'(age_entries[i].data);
            end
            if (age_valid[i] && age_entries[i].addr == raddr_b_i) begin
                hit_b = 1'b1;
                byp_b = DataWidth'(age_entries[i].data);
            end
        end
        if (push && waddr_i == raddr_a_i) begin
            hit_a = 1'b1;
            byp_a = wdata_i;
        end
        if (push && waddr_i == raddr_b_i) begin
            hit_b = 1'b1;
            byp_b = wdata_i;
        end
    end

    // ---- issue -> p1: capture bypass decision at the issue edge ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            zero_a_p1 <= 1'b1;
            zero_b_p1 <= 1'b1;
            hit_a_p1  <= 1'b0;
            hit_b_p1  <= 1'b0;
        end else begin
            vld_p1    <= issue;
            zero_a_p1 <= (raddr_a_i == 5'd0);
            zero_b_p1 <= (raddr_b_i == 5'd0) | ~need_b_i;
            hit_a_p1  <= hit_a;
            hit_b_p1  <= hit_b;
        end
    end

    always_ff @(posedge clk_i) begin
        byp_a_p1 <= byp_a;
        byp_b_p1 <= byp_b;
    end

    // ---- p1: merge bypass data with SRAM data ----
    assign rd_valid_o = vld_p1;
    assign rdata_a_o  = (vld_p1 && !zero_a_p1) ?
                        (hit_a_p1 ? byp_a_p1 : DataWidth'(rf.rf_rdata_a_i)) : '0;
    assign rdata_b_o  = (vld_p1 && !zero_b_p1) ?
                        (hit_b_p1 ? byp_b_p1 : DataWidth'(rf.rf_rdata_b_i)) : '0;
endmodule
